// File: rtl/assoc_cache_ram.sv
// N-way set-associative tag/status/data storage with hit compare and victim select.
// Optional CACHE_RAM_PLRU_EN selects per-set tree pseudo-LRU instead of global round-robin.
module assoc_cache_ram #(
  parameter  int TAG_LEN    = 13,
  parameter  int INDEX_LEN  = 10,
  parameter  int OFFSET_LEN = 4,
  parameter  int WAYS       = 2,
  localparam int WAY_W      = $clog2(WAYS),
  localparam int LINE_W     = 32 * (2 ** (OFFSET_LEN - 2)),
  localparam int SETS       = 2 ** INDEX_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_req_op,
  input  logic [INDEX_LEN-1:0]  i_req_index,
  input  logic [TAG_LEN-1:0]    i_req_tag,
  input  logic [WAY_W-1:0]      i_req_way,
  input  logic [OFFSET_LEN-3:0] i_req_word,
  input  logic [31:0]           i_req_wdata,
  input  logic [3:0]            i_req_be,
  input  logic [LINE_W-1:0]     i_fill_data,
  input  logic [2:0]            i_fill_status,
  output logic                  o_resp_valid,
  output logic                  o_resp_hit,
  output logic [WAY_W-1:0]      o_resp_way,
  output logic [TAG_LEN-1:0]    o_resp_tag,
  output logic [2:0]            o_resp_status,
  output logic [LINE_W-1:0]     o_resp_data
);
  localparam logic [1:0] S_INIT = 2'd0, S_IDLE = 2'd1, S_WWR = 2'd2;
  localparam logic [1:0] OP_LOOK = 2'd0, OP_FILL = 2'd1, OP_WR = 2'd2, OP_INV = 2'd3;

  logic [1:0]            r_state;
  logic [INDEX_LEN-1:0]  r_cnt;
  logic                  r_vld;
  logic [1:0]            r_op;
  logic [INDEX_LEN-1:0]  r_index;
  logic [TAG_LEN-1:0]    r_tag;
  logic [WAY_W-1:0]      r_way, r_pol_way;
  logic [OFFSET_LEN-3:0] r_word;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;

  logic                             w_acc, w_hit, w_look, w_wwr, w_inv_any;
  logic [WAY_W-1:0]                 w_hit_way, w_inv_way, w_victim, w_sel, w_pol_way;
  logic [WAYS-1:0][TAG_LEN-1:0]     w_rd_tag;
  logic [WAYS-1:0][2:0]             w_rd_stat;
  logic [WAYS-1:0][LINE_W-1:0]      w_rd_data;
  logic [LINE_W-1:0]                w_wline;

  assign o_req_ready = (r_state == S_IDLE);
  assign w_acc       = i_req_valid && o_req_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) r_state <= S_IDLE;
        end
        S_IDLE:  if (w_acc && i_req_op == OP_WR) r_state <= S_WWR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_vld <= 1'b0; r_op <= OP_LOOK; r_index <= '0; r_tag <= '0; r_way <= '0;
      r_word <= '0; r_wdata <= '0; r_be <= '0; r_pol_way <= '0;
    end else begin
      r_vld <= w_acc;
      if (w_acc) begin
        r_op <= i_req_op; r_index <= i_req_index; r_tag <= i_req_tag; r_way <= i_req_way;
        r_word <= i_req_word; r_wdata <= i_req_wdata; r_be <= i_req_be; r_pol_way <= w_pol_way;
      end
    end
  end

  // Lowest-numbered way wins both the hit scan and the invalid-way scan.
  always_comb begin
    w_hit = 1'b0; w_hit_way = '0; w_inv_any = 1'b0; w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_rd_stat[w][0] && w_rd_tag[w] == r_tag) begin
        w_hit = 1'b1; w_hit_way = WAY_W'(w);
      end
      if (!w_rd_stat[w][0]) begin
        w_inv_any = 1'b1; w_inv_way = WAY_W'(w);
      end
    end
    w_look   = (r_op == OP_LOOK) || (r_op == OP_WR);
    w_victim = w_inv_any ? w_inv_way : r_pol_way;
    w_sel    = !w_look ? r_way : (w_hit ? w_hit_way : w_victim);
  end

  assign w_wwr = (r_state == S_WWR) && w_hit;

  always_comb begin
    w_wline = w_rd_data[w_hit_way];
    for (int b = 0; b < 4; b++)
      if (r_be[b]) w_wline[int'(r_word) * 32 + b * 8 +: 8] = r_wdata[b * 8 +: 8];
  end

  assign o_resp_valid  = r_vld;
  assign o_resp_hit    = w_look && w_hit;
  assign o_resp_way    = w_sel;
  assign o_resp_tag    = w_rd_tag[w_sel];
  assign o_resp_status = w_rd_stat[w_sel];
  assign o_resp_data   = w_rd_data[w_sel];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic [TAG_LEN-1:0] m_tag  [SETS];
    logic [2:0]         m_stat [SETS];
    logic [LINE_W-1:0]  m_data [SETS];
    logic [TAG_LEN-1:0] r_rd_tag;
    logic [2:0]         r_rd_stat;
    logic [LINE_W-1:0]  r_rd_data;
    logic               w_fsel, w_isel;

    assign w_fsel = (i_req_way == WAY_W'(g)) && (i_req_op == OP_FILL);
    assign w_isel = (i_req_way == WAY_W'(g)) && (i_req_op == OP_INV);

    always_ff @(posedge i_clk) begin
      if (r_state == S_INIT) begin
        m_tag[r_cnt]  <= '0;
        m_stat[r_cnt] <= '0;
      end else if (w_acc && w_fsel) begin
        m_tag[i_req_index]  <= i_req_tag;
        m_stat[i_req_index] <= i_fill_status;
        m_data[i_req_index] <= i_fill_data;
      end else if (w_acc && w_isel) begin
        m_stat[i_req_index] <= m_stat[i_req_index] & 3'b100;
      end else if (w_wwr && w_hit_way == WAY_W'(g)) begin
        m_data[r_index] <= w_wline;
        m_stat[r_index] <= r_rd_stat | 3'b010;
      end
    end

    // Read port returns pre-write contents; fill/invalidate report the values just written.
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_rd_tag <= '0; r_rd_stat <= '0; r_rd_data <= '0;
      end else if (w_acc) begin
        r_rd_tag  <= w_fsel ? i_req_tag : m_tag[i_req_index];
        r_rd_stat <= w_fsel ? i_fill_status :
                     w_isel ? (m_stat[i_req_index] & 3'b100) : m_stat[i_req_index];
        r_rd_data <= w_fsel ? i_fill_data : m_data[i_req_index];
      end
    end

    assign w_rd_tag[g]  = r_rd_tag;
    assign w_rd_stat[g] = r_rd_stat;
    assign w_rd_data[g] = r_rd_data;
  end

`ifdef CACHE_RAM_PLRU_EN
  function automatic logic [WAY_W-1:0] f_vict(input logic [WAYS-2:0] t);
    logic [WAY_W-1:0] v; int n; logic b;
    v = '0; n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = t[n]; v = WAY_W'({v, b}); n = 2 * n + 1 + int'(b);
    end
    return v;
  endfunction

  // Point every node on the path away from the accessed way.
  function automatic logic [WAYS-2:0] f_upd(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] w);
    logic [WAYS-2:0] r; int n; logic b;
    r = t; n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = w[WAY_W-1-l]; r[n] = ~b; n = 2 * n + 1 + int'(b);
    end
    return r;
  endfunction

  logic [WAYS-2:0] r_plru [SETS];
  logic            w_pupd;
  logic [WAYS-2:0] w_pnew, w_pbase;

  assign w_pupd    = r_vld && w_look && w_hit;
  assign w_pnew    = f_upd(r_plru[r_index], w_hit_way);
  assign w_pbase   = (w_pupd && i_req_index == r_index) ? w_pnew : r_plru[i_req_index];
  assign w_pol_way = f_vict(w_pbase);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else begin
      if (w_pupd) r_plru[r_index] <= w_pnew;
      if (w_acc && i_req_op == OP_FILL) r_plru[i_req_index] <= f_upd(w_pbase, i_req_way);
    end
  end
`else
  logic [WAY_W-1:0] r_rr;

  assign w_pol_way = r_rr;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                          r_rr <= '0;
    else if (w_acc && i_req_op == OP_FILL) r_rr <= r_rr + 1'b1;
  end
`endif
endmodule
